// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_sync_param.
//   master : producer/consumer side; drives wr_en/din/rd_en and observes everything else
//   slave  : FIFO side; samples requests and drives data, occupancy, state, flags, acks
// DATA_WIDTH and DEPTH must match the fifo_sync_param instance that the interface is bound to.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic [CW-1:0]         data_count;
  logic [2:0]            state;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output wr_en, din, rd_en,
    input  dout, data_count, state, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, data_count, state, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock synchronous FIFO with an occupancy counter, an operation-state
// register and registered handshake pulses.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register except the storage array
//   bus   : fifo_sync_param_if.slave
//           wr_en/din   write request and data
//           rd_en/dout  read request and registered read data (one-cycle latency)
//           data_count  registered occupancy 0..DEPTH
//           state       last operation: INIT/READ/WRITE/RD_ERROR/WR_ERROR/NO_OP/RD_WR
//           full/empty/almost_full/almost_empty  decoded from data_count
//           wr_ack/wr_err/rd_ack/rd_err          one-cycle pulses after the sampling edge
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,   // power of two, >= 2
  parameter int AF_THRESH  = 6,   // 1..DEPTH
  parameter int AE_THRESH  = 2    // 0..DEPTH-1
) (
  input  logic              clk,
  input  logic              reset,
  fifo_sync_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  typedef enum logic [2:0] {
    S_INIT     = 3'b000,
    S_READ     = 3'b001,
    S_WRITE    = 3'b010,
    S_RD_ERROR = 3'b011,
    S_WR_ERROR = 3'b100,
    S_NO_OP    = 3'b101,
    S_RD_WR    = 3'b110
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  state_t                state_q, state_d;
  logic                  wacc, racc, werr, rerr;

  // Acceptance uses the pre-edge count only, so a read never frees room for a
  // same-edge write when full, and a write never feeds a same-edge read when empty.
  always_comb begin
    wacc    = bus.wr_en && (count_q != DEPTH_C);
    racc    = bus.rd_en && (count_q != '0);
    werr    = bus.wr_en && !wacc;
    rerr    = bus.rd_en && !racc;
    count_d = count_q + CW'(wacc) - CW'(racc);

    // Next state ignores the current state, so an illegal 3'b111 self-clears.
    state_d = S_NO_OP;
    if (werr)              state_d = S_WR_ERROR;
    else if (rerr)         state_d = S_RD_ERROR;
    else if (wacc && racc) state_d = S_RD_WR;
    else if (wacc)         state_d = S_WRITE;
    else if (racc)         state_d = S_READ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wacc) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wacc) wr_ptr <= wr_ptr + AW'(1);
      // Reads the slot before this edge's write lands, so a simultaneous
      // read/write always returns the oldest entry.
      if (racc) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      wr_ack_q <= wacc;
      wr_err_q <= werr;
      rd_ack_q <= racc;
      rd_err_q <= rerr;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.data_count   = count_q;
  assign bus.state        = state_q;
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_err       = rd_err_q;
endmodule
